// File: rtl/pri_codec_pkg.sv
// Shared definitions for the priority encode/decode path.
// Both the encoder and the receive-side decoder/accumulator import this package.
package pri_codec_pkg;

  localparam int IDX_W = 3;
  localparam int VEC_W = 1 << IDX_W;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder.
// When the enable is low, no bit is set.
module onehot_dec
  import pri_codec_pkg::*;
(
  input  idx_t idx,
  input  logic en,
  output vec_t onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/pri_decoder_accum.sv
// Rebuilds 8-bit request vectors from encoded beats.
// Each group is accumulated, then emitted on a registered valid/ready port.
module pri_decoder_accum
  import pri_codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IDX_W-1:0] s_idx,
  input  logic             s_hit,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [VEC_W-1:0] m_mask,
  output logic [CNT_W-1:0] m_count,
  output logic             m_dup,
  output logic             m_ord_err
);

  acc_state_t state, state_d;

  vec_t acc_mask;
  cnt_t acc_cnt;
  logic acc_dup;
  logic acc_ord;
  idx_t prev_idx;
  logic prior_hit;

  vec_t hit_bit;
  logic already_set;
  logic accept;

  vec_t nxt_mask;
  cnt_t nxt_cnt;
  logic nxt_dup;
  logic nxt_ord;
  idx_t nxt_prev;
  logic nxt_prior;

  // Input stalls only while a finished group is held at the output.
  assign s_ready = ~m_valid | m_ready;
  assign accept  = s_valid & s_ready;

  onehot_dec u_dec (
    .idx    (s_idx),
    .en     (s_hit),
    .onehot (hit_bit)
  );

  assign already_set = |(acc_mask & hit_bit);

  // Accumulator update for the current beat, including its contribution.
  always_comb begin
    nxt_mask  = acc_mask | hit_bit;
    nxt_cnt   = acc_cnt + {{(CNT_W-1){1'b0}}, (s_hit & ~already_set)};
    nxt_dup   = acc_dup | (s_hit & already_set);
    nxt_ord   = acc_ord;
    if (s_hit && (state == ACC) && prior_hit && (s_idx > prev_idx))
      nxt_ord = 1'b1;
    nxt_prev  = s_hit ? s_idx : prev_idx;
    nxt_prior = prior_hit | s_hit;
  end

  always_comb begin
    state_d = state;
    if (accept) state_d = s_last ? IDLE : ACC;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Accumulator: clears on group close so the next beat starts a fresh group.
  always_ff @(posedge clk) begin
    if (rst || (accept && s_last)) begin
      acc_mask  <= '0;
      acc_cnt   <= '0;
      acc_dup   <= 1'b0;
      acc_ord   <= 1'b0;
      prev_idx  <= '0;
      prior_hit <= 1'b0;
    end else if (accept) begin
      acc_mask  <= nxt_mask;
      acc_cnt   <= nxt_cnt;
      acc_dup   <= nxt_dup;
      acc_ord   <= nxt_ord;
      prev_idx  <= nxt_prev;
      prior_hit <= nxt_prior;
    end
  end

  // Output stage: a closing beat can load while the previous group hands off.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_mask    <= '0;
      m_count   <= '0;
      m_dup     <= 1'b0;
      m_ord_err <= 1'b0;
    end else if (accept && s_last) begin
      m_valid   <= 1'b1;
      m_mask    <= nxt_mask;
      m_count   <= nxt_cnt;
      m_dup     <= nxt_dup;
      m_ord_err <= nxt_ord;
    end else if (m_ready) begin
      m_valid   <= 1'b0;
    end
  end

endmodule
